palindrome_tx: RTL and testbench

//   Source end of the palindrome path. Builds a WIDTH-bit palindrome from a

---
 rtl/palindrome_pkg.sv | 38 +++
 rtl/palindrome_ser.sv | 67 ++++++
 rtl/palindrome_tx.sv | 132 +++++++++++++
 tb/tb_palindrome_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/palindrome_pkg.sv
// rtl/palindrome_pkg.sv - shared types and helpers for the palindrome source path
//
// Purpose:
//   Shared definitions for palindrome_tx and palindrome_ser.
//   - ptx_state_t : transmitter FSM states.
//   - mirror()    : reverses the low w bits of a half-word.
//   - width localparams used when the parameter is not otherwise supplied.
// Ports: none (package).
package palindrome_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ptx_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_HALF  = DEFAULT_WIDTH / 2;

  // Widest half-word mirror() can handle. Callers zero-extend their half-word
  // into this width and pass the real width in w.
  localparam int unsigned MIRROR_MAX = 32;

  // Returns h[w-1:0] with its bit order reversed, in bits [w-1:0] of the result:
  // result[i] = h[w-1-i]. The full vector is reversed and then shifted down so
  // the reversed low w bits land at the bottom; the zero padding falls off.
  function automatic logic [MIRROR_MAX-1:0] mirror(
    input logic [MIRROR_MAX-1:0] h,
    input int unsigned           w
  );
    logic [MIRROR_MAX-1:0] rev;
    for (int i = 0; i < MIRROR_MAX; i++) begin
      rev[i] = h[MIRROR_MAX-1-i];
    end
    return rev >> (MIRROR_MAX - w);
  endfunction

endpackage

// File: rtl/palindrome_ser.sv
// rtl/palindrome_ser.sv - MSB-first serialiser with valid/ready and first/last flags
//
// Purpose:
//   WIDTH-bit shift register plus a down-counting bit index. Loaded in
//   parallel, then shifted out MSB-first one bit per accepted transfer.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   load       in   parallel-load load_word and set idx to WIDTH-1
//   load_word  in   WIDTH-bit word to serialise
//   shift_en   in   owner is in its shifting phase; drives ser_valid
//   ser_ready  in   sink accepts the current bit
//   ser_valid  out  current bit is valid
//   ser_bit    out  current bit (MSB first)
//   ser_first  out  current bit is bit WIDTH-1
//   ser_last   out  current bit is bit 0
//   last_xfer  out  bit 0 is being accepted this cycle
module palindrome_ser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             shift_en,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             ser_last,
  output logic             last_xfer
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic             xfer;

  assign xfer = shift_en && ser_ready;

  // Without a transfer nothing moves, so a stalled sink sees the same bit
  // and flags until it accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= load_word;
      idx  <= IDX_TOP;
    end else if (xfer) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      if (idx != '0) begin
        idx <= idx - 1'b1;
      end
    end
  end

  // Gated by shift_en so the stream outputs read 0 outside the shifting phase.
  assign ser_valid = shift_en;
  assign ser_bit   = shift_en && sreg[WIDTH-1];
  assign ser_first = shift_en && (idx == IDX_TOP);
  assign ser_last  = shift_en && (idx == '0);
  assign last_xfer = xfer && (idx == '0);

endmodule

// File: rtl/palindrome_tx.sv
// rtl/palindrome_tx.sv - palindrome word builder and MSB-first bit-stream transmitter
//
// Purpose:
//   Builds word = {h, mirror(h)} from a half-word h taken from in_half
//   (manual mode) or from an internal enumeration counter (auto mode),
//   serialises it MSB-first and holds it on par_word for the detector.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   mode_auto  in   1 = half-word from counter, 0 = from in_half (sampled in IDLE)
//   in_valid   in   in_half valid (manual mode only)
//   in_half    in   WIDTH/2-bit upper half of the word
//   in_ready   out  can accept a new word (IDLE)
//   ser_valid  out  ser_bit valid
//   ser_ready  in   sink accepts ser_bit
//   ser_bit    out  serial bit, MSB first
//   ser_first  out  first bit of the word
//   ser_last   out  last bit of the word
//   par_word   out  last word built, held until the next load
//   word_done  out  one-cycle pulse after the last bit is accepted
module palindrome_tx
  import palindrome_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_auto,
  input  logic                 in_valid,
  input  logic [WIDTH/2-1:0]   in_half,
  output logic                 in_ready,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_bit,
  output logic                 ser_first,
  output logic                 ser_last,
  output logic [WIDTH-1:0]     par_word,
  output logic                 word_done
);

  localparam int unsigned HALF = WIDTH / 2;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0) || (HALF > MIRROR_MAX)) begin : g_width_check
    $error("palindrome_tx: WIDTH must be even, >= 2 and <= 2*MIRROR_MAX");
  end

  ptx_state_t       state;
  ptx_state_t       next_state;
  logic [HALF-1:0]  count;
  logic             word_auto;
  logic [HALF-1:0]  src_half;
  logic [WIDTH-1:0] new_word;
  logic             load;
  logic             shift_en;
  logic             last_xfer;

  // Auto mode reloads on every IDLE cycle, so it never waits on in_valid.
  assign load     = (state == IDLE) && (mode_auto || in_valid);
  assign src_half = mode_auto ? count : in_half;
  assign new_word = {src_half, HALF'(mirror(MIRROR_MAX'(src_half), HALF))};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (load)      next_state = SHIFT;
      SHIFT:   if (last_xfer) next_state = DONE;
      DONE:                   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Output logic. in_ready is also gated by rst so it reads 0 for the whole
  // reset, not just from the second reset cycle onwards.
  always_comb begin
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    unique case (state)
      IDLE:    in_ready  = !rst;
      SHIFT:   shift_en  = 1'b1;
      DONE:    word_done = 1'b1;
      default: ;
    endcase
  end

  // par_word, enumeration counter and the per-word mode capture. The mode is
  // captured at load so a mid-word toggle of mode_auto cannot change whether
  // the counter advances for the word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_word  <= '0;
      count     <= '0;
      word_auto <= 1'b0;
    end else begin
      if (load) begin
        par_word  <= new_word;
        word_auto <= mode_auto;
      end
      if ((state == DONE) && word_auto) begin
        count <= count + 1'b1;
      end
    end
  end

  palindrome_ser #(
    .WIDTH (WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_word (new_word),
    .shift_en  (shift_en),
    .ser_ready (ser_ready),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .last_xfer (last_xfer)
  );

endmodule

// File: tb/tb_palindrome_tx.sv
// tb/tb_palindrome_tx.sv - self-checking bench for palindrome_tx (WIDTH=8)
module tb_palindrome_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_auto;
  logic       in_valid;
  logic [3:0] in_half;
  logic       in_ready;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_bit;
  logic       ser_first;
  logic       ser_last;
  logic [7:0] par_word;
  logic       word_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         bit_cnt = 0;
  logic [7:0] acc     = 8'h00;

  typedef struct {
    logic [3:0] half;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  palindrome_tx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_auto (mode_auto),
    .in_valid  (in_valid),
    .in_half   (in_half),
    .in_ready  (in_ready),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_bit   (ser_bit),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .par_word  (par_word),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
  endfunction

  function automatic logic [7:0] pal_of(input logic [3:0] h);
    return {h, h[0], h[1], h[2], h[3]};
  endfunction

  // Scoreboard side: collect accepted bits, compare each whole word with the
  // oldest expected entry.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      bit_cnt = 0;
    end else if (ser_valid && ser_ready) begin
      check("ser_first", 32'(ser_first), 32'(bit_cnt == 0));
      check("ser_last", 32'(ser_last), 32'(bit_cnt == 7));
      acc = {acc[6:0], ser_bit};
      bit_cnt++;
      if (bit_cnt == 8) begin
        bit_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(acc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("ser_word", 32'(acc), 32'(e));
          check("par_word", 32'(par_word), 32'(e));
          check("palindrome", 32'(rev8(par_word)), 32'(par_word));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_manual(input logic [3:0] h, input logic [7:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_half  = h;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!word_done && n < 100) begin
      tick();
      n++;
    end
    check("word_done_seen", 32'(word_done), 32'd1);
  endtask

  initial begin
    int n;
    int pulses;

    vecs[0] = '{4'b1110, 8'b11100111};
    vecs[1] = '{4'b1011, 8'b10111101};
    vecs[2] = '{4'b0001, 8'b00011000};
    vecs[3] = '{4'b0000, 8'b00000000};
    vecs[4] = '{4'b1111, 8'b11111111};
    vecs[5] = '{4'b1000, 8'b10000001};

    rst       = 1'b1;
    mode_auto = 1'b0;
    in_valid  = 1'b0;
    in_half   = 4'h0;
    ser_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_ser_bit", 32'(ser_bit), 32'd0);
    check("rst_ser_first", 32'(ser_first), 32'd0);
    check("rst_ser_last", 32'(ser_last), 32'd0);
    check("rst_word_done", 32'(word_done), 32'd0);
    check("rst_par_word", 32'(par_word), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Manual words from the table; latency measured in cycles after load edge.
    for (int i = 0; i < 6; i++) begin
      send_manual(vecs[i].half, vecs[i].exp_word);
      check("first_bit_valid", 32'(ser_valid), 32'd1);
      wait_done(n);
      check("word_done_cycle", 32'(n + 1), 32'd9);
      check("par_word_hold", 32'(par_word), 32'(vecs[i].exp_word));
      tick();
      check("done_one_cycle", 32'(word_done), 32'd0);
    end

    // Backpressure at bit index 4 for 3 cycles.
    send_manual(4'b1110, 8'b11100111);
    tick();
    tick();
    tick();
    ser_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", 32'(ser_valid), 32'd1);
      check("stall_bit", 32'(ser_bit), 32'd0);
      check("stall_first", 32'(ser_first), 32'd0);
      check("stall_last", 32'(ser_last), 32'd0);
    end
    ser_ready = 1'b1;
    wait_done(n);
    check("stall_done_cycle", 32'(6 + n + 1), 32'd12);
    tick();

    // Auto mode: 17 words, wrapping back to 0. in_valid/in_half are ignored.
    for (int c = 0; c < 17; c++) begin
      exp_q.push_back(pal_of(4'(c % 16)));
    end
    in_valid  = 1'b1;
    in_half   = 4'b1010;
    mode_auto = 1'b1;
    for (int w = 0; w < 17; w++) begin
      wait_done(n);
      check("auto_word", 32'(par_word), 32'(pal_of(4'(w % 16))));
      if (w == 16) begin
        mode_auto = 1'b0;
        in_valid  = 1'b0;
      end
      tick();
    end
    tick();
    check("auto_stops", 32'(ser_valid), 32'd0);

    // Reset mid-SHIFT at bit index 5.
    send_manual(4'b1110, 8'b11100111);
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("abort_ser_valid", 32'(ser_valid), 32'd0);
    check("abort_ser_bit", 32'(ser_bit), 32'd0);
    check("abort_first_last", 32'({ser_first, ser_last}), 32'd0);
    check("abort_par_word", 32'(par_word), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (word_done) pulses++;
      tick();
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    send_manual(4'b0001, 8'b00011000);
    wait_done(n);
    check("after_abort_cycle", 32'(n + 1), 32'd9);
    tick();
    // Counter was cleared by reset, so the next auto word is all zeros.
    exp_q.push_back(8'b00000000);
    mode_auto = 1'b1;
    wait_done(n);
    mode_auto = 1'b0;
    check("counter_cleared", 32'(par_word), 32'd0);
    tick();
    tick();

    // in_valid during SHIFT is ignored.
    send_manual(4'b1011, 8'b10111101);
    tick();
    in_valid = 1'b1;
    in_half  = 4'b0100;
    tick();
    check("shift_in_ready", 32'(in_ready), 32'd0);
    check("shift_par_word", 32'(par_word), 32'b10111101);
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("ignore_par_word", 32'(par_word), 32'b10111101);
    tick();
    tick();
    check("idle_after_ignore", 32'({in_ready, ser_valid}), 32'b10);
    check("idle_par_word", 32'(par_word), 32'b10111101);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
